// File: rtl/palette_writer.sv
// rtl/palette_writer.sv - VGA-DAC style palette write front end with blank-gated commit FIFO
//
// Purpose: CPU byte writes set a 9-bit index and then stream R, G, B bytes.
// Each completed triple is queued and later written to the palette RAM, but
// only while blank is high, so the visible image never tears.
//
// Ports:
//   clk_pix    in   1   pixel/system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   bus_addr   in   2   0 idx low, 1 idx high, 2 data, 3 status
//   bus_wdata  in   8   write data
//   bus_we     in   1   write strobe
//   bus_re     in   1   read strobe
//   bus_rdata  out  8   registered read data
//   blank      in   1   palette is free to be written
//   pal_we     out  1   palette RAM write enable
//   pal_addr   out  9   palette RAM write address
//   pal_wdata  out  24  palette RAM write data {R,G,B}
//   busy       out  1   entries still queued
module palette_writer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_pix,
    input  logic        rst_n,
    input  logic [1:0]  bus_addr,
    input  logic [7:0]  bus_wdata,
    input  logic        bus_we,
    input  logic        bus_re,
    output logic [7:0]  bus_rdata,
    input  logic        blank,
    output logic        pal_we,
    output logic [8:0]  pal_addr,
    output logic [23:0] pal_wdata,
    output logic        busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        PH_R = 2'd0,
        PH_G = 2'd1,
        PH_B = 2'd2
    } phase_t;

    // Reset asserts immediately but is released only on a clock edge, so the
    // rest of the block never sees a release close to the active edge.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    phase_t         phase_q, phase_d;
    logic [8:0]     idx;
    logic [7:0]     r_lat, g_lat;
    logic           overflow;
    logic           push_req;

    logic [32:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           empty, full;
    logic           pop, push_ok, push_drop;
    logic           status_rd;

    assign empty     = (count == '0);
    assign full      = (count == DEPTH_C);
    assign pop       = blank & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok   = push_req & (~full | pop);
    assign push_drop = push_req & ~push_ok;
    assign status_rd = bus_re & (bus_addr == 2'd3);

    // Data-phase sequencer: index writes resynchronise it to R.
    always_ff @(posedge clk_pix or negedge rst_int_n) begin
        if (!rst_int_n) begin
            phase_q <= PH_R;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d  = phase_q;
        push_req = 1'b0;
        if (bus_we) begin
            case (bus_addr)
                2'd0, 2'd1: phase_d = PH_R;
                2'd2: begin
                    case (phase_q)
                        PH_R:    phase_d = PH_G;
                        PH_G:    phase_d = PH_B;
                        PH_B: begin
                            push_req = 1'b1;
                            phase_d  = PH_R;
                        end
                        default: phase_d = PH_R;
                    endcase
                end
                default: phase_d = phase_q;
            endcase
        end
    end

    // Index and colour latches.
    always_ff @(posedge clk_pix or negedge rst_int_n) begin
        if (!rst_int_n) begin
            idx   <= '0;
            r_lat <= '0;
            g_lat <= '0;
        end else if (bus_we) begin
            case (bus_addr)
                2'd0: idx[7:0] <= bus_wdata;
                2'd1: idx[8]   <= bus_wdata[0];
                2'd2: begin
                    if (phase_q == PH_R) begin
                        r_lat <= bus_wdata;
                    end else if (phase_q == PH_G) begin
                        g_lat <= bus_wdata;
                    end else begin
                        // Advance even when the push is dropped.
                        idx <= idx + 9'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Entry storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk_pix) begin
        if (push_ok) begin
            mem[wr_ptr] <= {idx, r_lat, g_lat, bus_wdata};
        end
    end

    always_ff @(posedge clk_pix or negedge rst_int_n) begin
        if (!rst_int_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a status read clears it unless a drop lands in the same cycle.
    always_ff @(posedge clk_pix or negedge rst_int_n) begin
        if (!rst_int_n) begin
            overflow <= 1'b0;
        end else if (push_drop) begin
            overflow <= 1'b1;
        end else if (status_rd) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk_pix or negedge rst_int_n) begin
        if (!rst_int_n) begin
            bus_rdata <= '0;
        end else if (bus_re) begin
            case (bus_addr)
                2'd0:    bus_rdata <= idx[7:0];
                2'd1:    bus_rdata <= {7'b0, idx[8]};
                2'd2:    bus_rdata <= 8'h00;
                default: bus_rdata <= {overflow, ~empty, full, 3'b000, phase_q};
            endcase
        end
    end

    assign pal_we    = pop;
    assign pal_addr  = mem[rd_ptr][32:24];
    assign pal_wdata = mem[rd_ptr][23:0];
    assign busy      = ~empty;

endmodule

// File: tb/tb_palette_writer.sv
// tb/tb_palette_writer.sv - self-checking bench for palette_writer
module tb_palette_writer;

    localparam int D = 4;

    logic        clk_pix = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  bus_addr = '0;
    logic [7:0]  bus_wdata = '0;
    logic        bus_we = 1'b0;
    logic        bus_re = 1'b0;
    logic [7:0]  bus_rdata;
    logic        blank = 1'b0;
    logic        pal_we;
    logic [8:0]  pal_addr;
    logic [23:0] pal_wdata;
    logic        busy;

    palette_writer #(.FIFO_DEPTH(D)) dut (
        .clk_pix   (clk_pix),
        .rst_n     (rst_n),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_re    (bus_re),
        .bus_rdata (bus_rdata),
        .blank     (blank),
        .pal_we    (pal_we),
        .pal_addr  (pal_addr),
        .pal_wdata (pal_wdata),
        .busy      (busy)
    );

    always #5 clk_pix = ~clk_pix;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of pending {addr, rgb} entries plus register state.
    int          m_idx;
    int          m_phase;
    logic [7:0]  m_r, m_g;
    bit          m_ovf;
    logic [7:0]  m_rd;
    logic [32:0] mq[$];

    task automatic model_reset();
        m_idx = 0; m_phase = 0; m_r = 0; m_g = 0; m_ovf = 0; m_rd = 0;
        mq.delete();
    endtask

    task automatic model_step(input bit we, input bit re, input int addr,
                              input logic [7:0] wd, input bit blk);
        bit pop;
        bit drop;
        pop  = blk && (mq.size() > 0);
        drop = 0;
        if (re) begin
            case (addr)
                0: m_rd = 8'(m_idx % 256);
                1: m_rd = 8'(m_idx / 256);
                2: m_rd = 8'h00;
                default: m_rd = {m_ovf, mq.size() != 0, mq.size() == D, 3'b000, 2'(m_phase)};
            endcase
        end
        if (pop) void'(mq.pop_front());
        if (we) begin
            case (addr)
                0: begin m_idx = (m_idx / 256) * 256 + wd; m_phase = 0; end
                1: begin m_idx = (m_idx % 256) + 256 * wd[0]; m_phase = 0; end
                2: begin
                    if (m_phase == 0) begin m_r = wd; m_phase = 1; end
                    else if (m_phase == 1) begin m_g = wd; m_phase = 2; end
                    else begin
                        if (mq.size() < D) mq.push_back({9'(m_idx), m_r, m_g, wd});
                        else drop = 1;
                        m_idx = (m_idx + 1) % 512;
                        m_phase = 0;
                    end
                end
                default: ;
            endcase
        end
        if (re && addr == 3) m_ovf = 0;
        if (drop) m_ovf = 1;
    endtask

    logic        s_we;
    logic [8:0]  s_addr;
    logic [23:0] s_data;

    // Called just after a falling edge: drive, check combinational outputs,
    // advance model across the rising edge, then check registered read data.
    task automatic tick(input bit we, input bit re, input int addr,
                        input logic [7:0] wd, input bit blk);
        bus_we = we; bus_re = re; bus_addr = 2'(addr); bus_wdata = wd; blank = blk;
        #1;
        s_we = pal_we; s_addr = pal_addr; s_data = pal_wdata;
        chk("pal_we", pal_we, blk && mq.size() > 0);
        if (blk && mq.size() > 0) begin
            chk("pal_addr", pal_addr, mq[0][32:24]);
            chk("pal_wdata", pal_wdata, mq[0][23:0]);
        end
        chk("busy", busy, mq.size() > 0);
        model_step(we, re, addr, wd, blk);
        @(posedge clk_pix);
        @(negedge clk_pix);
        chk("bus_rdata", bus_rdata, m_rd);
        bus_we = 0; bus_re = 0;
    endtask

    task automatic wr(input int addr, input logic [7:0] wd, input bit blk);
        tick(1, 0, addr, wd, blk);
    endtask

    task automatic rd(input int addr, input bit blk);
        tick(0, 1, addr, 8'h00, blk);
    endtask

    typedef struct {
        bit         we;
        bit         re;
        int         addr;
        logic [7:0] wd;
        bit         blk;
        bit         x_we;
        logic [8:0] x_addr;
        logic [23:0] x_data;
        logic [7:0] x_rd;
    } vec_t;

    vec_t vt[$];
    int   nw;
    logic [8:0] seen[$];

    initial begin
        // Basic write, read back, and phase resync.
        vt.push_back('{1, 0, 0, 8'h05, 1, 0, 9'h000, 24'h0, 8'h00});
        vt.push_back('{1, 0, 2, 8'h11, 1, 0, 9'h000, 24'h0, 8'h00});
        vt.push_back('{1, 0, 2, 8'h22, 1, 0, 9'h000, 24'h0, 8'h00});
        vt.push_back('{1, 0, 2, 8'h33, 1, 0, 9'h000, 24'h0, 8'h00});
        vt.push_back('{0, 0, 0, 8'h00, 1, 1, 9'h005, 24'h112233, 8'h00});
        vt.push_back('{0, 1, 3, 8'h00, 1, 0, 9'h000, 24'h0, 8'h00});
        vt.push_back('{0, 1, 0, 8'h00, 1, 0, 9'h000, 24'h0, 8'h06});
        vt.push_back('{0, 1, 1, 8'h00, 1, 0, 9'h000, 24'h0, 8'h00});
        vt.push_back('{1, 0, 2, 8'hAA, 1, 0, 9'h000, 24'h0, 8'h00});
        vt.push_back('{1, 0, 2, 8'hBB, 1, 0, 9'h000, 24'h0, 8'h00});
        vt.push_back('{0, 1, 3, 8'h00, 1, 0, 9'h000, 24'h0, 8'h02});
        vt.push_back('{1, 0, 0, 8'h10, 1, 0, 9'h000, 24'h0, 8'h02});
        vt.push_back('{0, 1, 3, 8'h00, 1, 0, 9'h000, 24'h0, 8'h00});
        vt.push_back('{1, 0, 2, 8'h01, 1, 0, 9'h000, 24'h0, 8'h00});
        vt.push_back('{1, 0, 2, 8'h02, 1, 0, 9'h000, 24'h0, 8'h00});
        vt.push_back('{1, 0, 2, 8'h03, 1, 0, 9'h000, 24'h0, 8'h00});
        vt.push_back('{0, 0, 0, 8'h00, 1, 1, 9'h010, 24'h010203, 8'h00});
        vt.push_back('{0, 0, 0, 8'h00, 1, 0, 9'h000, 24'h0, 8'h00});

        model_reset();
        repeat (2) @(negedge clk_pix);
        #1;
        chk("reset_pal_we", pal_we, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rdata", bus_rdata, 0);
        @(negedge clk_pix);
        rst_n = 1;
        repeat (3) tick(0, 0, 0, 8'h00, 0);

        foreach (vt[i]) begin
            tick(vt[i].we, vt[i].re, vt[i].addr, vt[i].wd, vt[i].blk);
            chk($sformatf("vec%0d_we", i), s_we, vt[i].x_we);
            if (vt[i].x_we) begin
                chk($sformatf("vec%0d_addr", i), s_addr, vt[i].x_addr);
                chk($sformatf("vec%0d_data", i), s_data, vt[i].x_data);
            end
            chk($sformatf("vec%0d_rd", i), bus_rdata, vt[i].x_rd);
        end

        // Wrap and deferral.
        wr(0, 8'hFF, 0);
        wr(1, 8'h01, 0);
        for (int k = 0; k < 9; k++) wr(2, 8'(k), 0);
        chk("defer_busy", busy, 1);
        seen.delete();
        for (int k = 0; k < 4; k++) begin
            tick(0, 0, 0, 8'h00, 1);
            if (s_we) seen.push_back(s_addr);
        end
        chk("wrap_n", seen.size(), 3);
        if (seen.size() == 3) begin
            chk("wrap_a0", seen[0], 9'h1FF);
            chk("wrap_a1", seen[1], 9'h000);
            chk("wrap_a2", seen[2], 9'h001);
        end
        chk("wrap_busy", busy, 0);

        // Overflow.
        wr(0, 8'h20, 0);
        wr(1, 8'h00, 0);
        for (int k = 0; k < 3 * (D + 1); k++) wr(2, 8'($urandom), 0);
        rd(3, 0);
        chk("ovf_rd1", bus_rdata, 8'hE0);
        rd(3, 0);
        chk("ovf_rd2", bus_rdata, 8'h60);
        nw = 0;
        for (int k = 0; k < D + 2; k++) begin
            tick(0, 0, 0, 8'h00, 1);
            nw += int'(s_we);
        end
        chk("ovf_writes", nw, D);
        rd(0, 1);
        chk("ovf_idx", bus_rdata, 8'h25);

        // Blank interrupt.
        for (int k = 0; k < 9; k++) wr(2, 8'(k + 1), 0);
        tick(0, 0, 0, 8'h00, 1);
        chk("int_first", s_we, 1);
        nw = 0;
        for (int k = 0; k < 5; k++) begin
            tick(0, 0, 0, 8'h00, 0);
            nw += int'(s_we);
        end
        chk("int_low", nw, 0);
        tick(0, 0, 0, 8'h00, 1);
        chk("int_r1", s_we, 1);
        tick(0, 0, 0, 8'h00, 1);
        chk("int_r2", s_we, 1);
        tick(0, 0, 0, 8'h00, 1);
        chk("int_done", s_we, 0);

        // Asynchronous reset in the middle of a drain.
        for (int k = 0; k < 9; k++) wr(2, 8'(k), 0);
        blank = 1;
        #1;
        chk("rst_pre_we", pal_we, 1);
        #2;
        rst_n = 0;
        #1;
        chk("rst_we", pal_we, 0);
        chk("rst_busy", busy, 0);
        model_reset();
        @(negedge clk_pix);
        rst_n = 1;
        nw = 0;
        for (int k = 0; k < 5; k++) begin
            tick(0, 0, 0, 8'h00, 1);
            nw += int'(s_we);
        end
        chk("rst_nowrites", nw, 0);
        rd(3, 1);
        chk("rst_status", bus_rdata, 8'h00);

        // Randomized traffic against the model.
        for (int k = 0; k < 2000; k++) begin
            tick(($urandom % 3) != 0, ($urandom % 4) == 0, int'($urandom % 4),
                 8'($urandom), ((k / 16) % 3) != 0 && ($urandom % 8) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/palette_writer.md
Name: palette_writer

Overview:
- Write-side front end for the 512-entry, 24-bit pixel palette RAM that the pixel pipeline reads.
- Accepts byte-wide CPU register writes in VGA-DAC style: set a 9-bit index, then send R, G, B bytes, with auto-increment.
- Queues completed entries in a small FIFO and commits them to the palette write port only while `blank` is high, so visible pixels never tear.

Parameters:
- FIFO_DEPTH, 4, number of queued palette entries; must be a power of two, minimum 2.

Ports:
- clk_pix  input  1  pixel/system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- bus_addr  input  2  register select: 0 = index low, 1 = index high, 2 = data, 3 = status.
- bus_wdata  input  8  write data.
- bus_we  input  1  write strobe, one cycle per access.
- bus_re  input  1  read strobe, one cycle per access.
- bus_rdata  output  8  registered read data.
- blank  input  1  high while the pixel pipeline is not fetching the palette.
- pal_we  output  1  palette RAM write enable.
- pal_addr  output  9  palette RAM write address.
- pal_wdata  output  24  palette RAM write data, {R,G,B}.
- busy  output  1  high while the FIFO is non-empty.

Behaviour:
- Reset (async assert, sync release) clears everything:
  - idx = 0, phase = R, r_lat = g_lat = 0.
  - FIFO empty, overflow = 0, bus_rdata = 0.
  - pal_we = 0 and busy = 0 immediately.
  - FIFO contents are discarded, including a drain in progress.
- All bus writes are sampled at the clk_pix edge when bus_we = 1.
  - addr 0: idx[7:0] <= wdata; phase <= R.
  - addr 1: idx[8] <= wdata[0]; phase <= R.
  - addr 2, phase R: r_lat <= wdata; phase <= G.
  - addr 2, phase G: g_lat <= wdata; phase <= B.
  - addr 2, phase B:
    - Push {idx, r_lat, g_lat, wdata} to the FIFO.
    - idx <= idx + 1, wrapping modulo 512 (0x1FF -> 0x000).
    - phase <= R.
  - addr 3: ignored.
- Push acceptance:
  - A push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the entry is dropped and overflow is set (sticky).
  - idx still increments and phase still returns to R on a dropped push.
- Status read: when bus_re = 1 and bus_addr = 3, bus_rdata is updated at the next edge to {overflow, busy, full, 3'b000, phase[1:0]}.
  - full = (count == FIFO_DEPTH).
  - phase encoding: R = 0, G = 1, B = 2.
  - The same edge clears overflow; an overflow set in that same cycle wins.
- Other reads: when bus_re = 1 and bus_addr ≠ 3, bus_rdata <= idx[7:0] (addr 0), {7'b0, idx[8]} (addr 1), or 0 (addr 2). Reads never change phase.
- bus_rdata holds its value when bus_re = 0.
- bus_we and bus_re asserted together: both take effect independently.
- Drain (combinational port):
  - pal_we = blank & !empty.
  - pal_addr and pal_wdata always show the FIFO head.
  - Each cycle with pal_we = 1 pops one entry, giving one write per clock in push order.
  - When blank falls, pal_we drops in the same cycle and undrained entries are retained.
- Latency: a data-B write at edge N makes the entry visible at the head after edge N. If blank = 1, pal_we is asserted in cycle N+1.
- busy = !empty (registered count-derived).

Test Plan:
1. Basic write:
   - Stimulus: blank = 1; write addr0 = 0x05, then addr2 = 0x11, 0x22, 0x33.
   - Response: exactly one pal_we cycle, the cycle after the B write, with pal_addr = 0x005 and pal_wdata = 0x112233. A status read then returns phase = 0, and an addr0 read returns 0x06.
2. Wrap and deferral:
   - Stimulus: blank = 0; idx = 0x1FF; write three RGB triples; then raise blank.
   - Response: busy = 1 and no pal_we while blank = 0. After blank rises, three consecutive pal_we cycles at addresses 0x1FF, 0x000, 0x001 in order; busy = 0 afterwards.
3. Overflow:
   - Stimulus: blank = 0; push FIFO_DEPTH + 1 entries; read status twice.
   - Response: first read = 0xE0 (overflow, busy, full); second read = 0x60. On draining, only the first 4 entries are written; idx advanced by 5.
4. Phase resync:
   - Stimulus: write R = 0xAA, G = 0xBB, then addr0 = 0x10, then data 0x01, 0x02, 0x03.
   - Response: a single entry with addr 0x010 and data 0x010203.
5. Blank interrupt:
   - Stimulus: 3 entries queued; blank high for 1 cycle, low for 5 cycles, then high.
   - Response: one write on the first blank cycle, none during the low period, then the remaining two on consecutive cycles.
6. Async reset mid-drain:
   - Stimulus: assert rst_n low between clock edges during a drain.
   - Response: pal_we = 0 and busy = 0 immediately. After release, blank = 1 produces no writes and status reads 0x00.
